// File: rtl/imm_encoder.sv
// RV32I immediate encoder: inserts a 32-bit immediate into the fields of a base
// instruction, flags unrepresentable immediates, one-stage valid/ready pipeline.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_imm_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic             err_flag,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr
);

  // Immediate type codes shared with the core's immediate-extend stage.
  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] encode(input logic [31:0] inst,
                                         input logic [31:0] imm,
                                         input logic [2:0]  t);
    logic [31:0] r;
    r = inst;
    case (t)
      ITYPE: r[31:20] = imm[11:0];
      STYPE: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      BTYPE: begin
        r[31]    = imm[12];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
        r[7]     = imm[11];
      end
      UTYPE: r[31:12] = imm[31:12];
      JTYPE: begin
        r[31]    = imm[20];
        r[30:21] = imm[10:1];
        r[20]    = imm[11];
        r[19:12] = imm[19:12];
      end
      default: r = inst;
    endcase
    return r;
  endfunction

  // Sign-range checks: value must survive truncation to the field's width.
  function automatic logic imm_err(input logic signed [31:0] imm,
                                   input logic [2:0]         t);
    logic e;
    case (t)
      RTYPE:        e = 1'b0;
      ITYPE, STYPE: e = (imm < -32'sd2048) || (imm > 32'sd2047);
      BTYPE:        e = (imm < -32'sd4096) || (imm > 32'sd4095) || imm[0];
      UTYPE:        e = (imm[11:0] != 12'd0);
      JTYPE:        e = (imm < -32'sd1048576) || (imm > 32'sd1048575) || imm[0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Stage p0: combinational encode and range check of the offered beat.
  logic              vld_p0;
  logic [31:0]       inst_p0;
  logic              err_p0;
  logic signed [31:0] imm_p0;

  assign vld_p0  = in_valid;
  assign imm_p0  = in_imm;
  assign inst_p0 = encode(in_inst, in_imm, in_imm_type);
  assign err_p0  = imm_err(imm_p0, in_imm_type);

  // Stage p1: output register.
  logic        vld_p1;
  logic [31:0] inst_p1;
  logic        err_p1;
  logic        out_acc;

  assign in_ready  = !vld_p1 || out_ready;
  assign out_valid = vld_p1;
  assign out_inst  = inst_p1;
  assign out_err   = err_p1;
  assign out_acc   = vld_p1 && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      inst_p1 <= 32'd0;
      err_p1  <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        inst_p1 <= inst_p0;
        err_p1  <= err_p0;
      end
    end
  end

  // Statistics, updated on accepted output beats; a clear still counts a coinciding beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt  <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clr) begin
      enc_cnt  <= out_acc ? CNT_ONE : '0;
      err_cnt  <= (out_acc && err_p1) ? CNT_ONE : '0;
      err_flag <= out_acc && err_p1;
    end else if (out_acc) begin
      enc_cnt <= sat_inc(enc_cnt);
      if (err_p1) begin
        err_cnt  <= sat_inc(err_cnt);
        err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder with hand-computed expected encodings.
module tb_imm_encoder;

  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        err_flag;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;
  logic        clr;

  int n_checks = 0;
  int n_fail   = 0;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_imm(in_imm), .in_imm_type(in_imm_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .err_flag(err_flag), .enc_cnt(enc_cnt), .err_cnt(err_cnt),
    .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for one edge; afterwards it sits on out_* (out_ready assumed 1 before).
  task automatic send(input logic [2:0] t, input logic [31:0] inst, input logic [31:0] imm);
    in_valid    = 1'b1;
    in_imm_type = t;
    in_inst     = inst;
    in_imm      = imm;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [2:0] t, input logic [31:0] inst,
                          input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_err);
    send(t, inst, imm);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_imm = '0; in_imm_type = RTYPE;
    out_ready = 1'b1; clr = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_flag", {31'd0, err_flag}, 32'd0);
    check("rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();

    // Field insertion and range checks
    send_chk("itype", ITYPE, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
    check("itype_cnt", {16'd0, enc_cnt}, 32'd1);
    check("itype_drop", {31'd0, out_valid}, 32'd0);
    send_chk("btype", BTYPE, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    send_chk("btype_odd", BTYPE, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b1);
    check("btype_errcnt", {16'd0, err_cnt}, 32'd1);
    check("btype_errflag", {31'd0, err_flag}, 32'd1);
    check("btype_enccnt", {16'd0, enc_cnt}, 32'd3);
    send_chk("jtype", JTYPE, 32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0);
    send_chk("utype", UTYPE, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0);
    send_chk("utype_low", UTYPE, 32'h0000_0037, 32'h1234_5001, 32'h1234_5037, 1'b1);
    send_chk("stype_min", STYPE, 32'h0000_0023, 32'hFFFF_F800, 32'h8000_0023, 1'b0);
    send_chk("itype_2048", ITYPE, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1);
    send_chk("rtype", RTYPE, 32'h0020_81B3, 32'hFFFF_FFFF, 32'h0020_81B3, 1'b0);
    check("mix_enccnt", {16'd0, enc_cnt}, 32'd9);
    check("mix_errcnt", {16'd0, err_cnt}, 32'd3);

    clr = 1'b1; step(); clr = 1'b0;
    check("clr_enccnt", {16'd0, enc_cnt}, 32'd0);
    check("clr_errcnt", {16'd0, err_cnt}, 32'd0);
    check("clr_errflag", {31'd0, err_flag}, 32'd0);

    // Backpressure and burst
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm_type = ITYPE; in_inst = 32'h0000_0013; in_imm = 32'd1;
    step();
    in_imm = 32'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_inst", out_inst, 32'h0010_0013);
      check("bp_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("burst_b1", out_inst, 32'h0020_0013);
    in_imm = 32'd3;
    step();
    check("burst_b2", out_inst, 32'h0030_0013);
    in_imm = 32'd4;
    step();
    check("burst_b3", out_inst, 32'h0040_0013);
    in_valid = 1'b0;
    step();
    check("burst_drop", {31'd0, out_valid}, 32'd0);
    check("burst_cnt", {16'd0, enc_cnt}, 32'd4);

    // Saturation
    clr = 1'b1; step(); clr = 1'b0;
    in_valid = 1'b1; in_imm_type = RTYPE; in_inst = 32'h0000_0033; in_imm = '0;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    step();
    check("sat_reach", {16'd0, enc_cnt}, 32'h0000_FFFF);
    send(RTYPE, 32'h0000_0033, 32'd0);
    step();
    check("sat_hold", {16'd0, enc_cnt}, 32'h0000_FFFF);
    check("sat_errcnt", {16'd0, err_cnt}, 32'd0);

    // Clear coinciding with an accepted error beat (undefined type code)
    send(3'd7, 32'h1234_5678, 32'd0);
    check("undef_err", {31'd0, out_err}, 32'd1);
    check("undef_inst", out_inst, 32'h1234_5678);
    clr = 1'b1; step(); clr = 1'b0;
    check("clracc_enccnt", {16'd0, enc_cnt}, 32'd1);
    check("clracc_errcnt", {16'd0, err_cnt}, 32'd1);
    check("clracc_errflag", {31'd0, err_flag}, 32'd1);

    // Asynchronous reset during a stalled beat
    out_ready = 1'b0;
    send(ITYPE, 32'h0000_0013, 32'd5);
    check("pre_rst_vld", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", {31'd0, out_valid}, 32'd0);
    check("arst_enccnt", {16'd0, enc_cnt}, 32'd0);
    check("arst_errflag", {31'd0, err_flag}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    check("post_rst_vld", {31'd0, out_valid}, 32'd0);
    send_chk("post_rst", ITYPE, 32'h0000_0093, 32'h0000_07FF, 32'h7FF0_0093, 1'b0);
    check("post_rst_cnt", {16'd0, enc_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate-extend stage: takes a base instruction word, a full 32-bit immediate and an immediate type, and inserts the immediate bits into the RV32I instruction fields.
- Flags immediates that cannot be represented in the chosen format.
- Sits on the debug/test instruction-generation path ahead of instruction memory writes.
- Registered, one-stage valid/ready pipeline with saturating beat and error counters.

Parameters:
- CNT_W, 16, width of the encoded-beat and error counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_inst  input  32  base instruction; opcode/rd/rs1/rs2/funct bits are kept.
- in_imm  input  32  full immediate value, two's complement.
- in_imm_type  input  3  immediate type, encoded with the Parameters.v macros ITYPE/RTYPE/STYPE/BTYPE/UTYPE/JTYPE.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_inst  output  32  encoded instruction.
- out_err  output  1  immediate not representable for this beat.
- err_flag  output  1  sticky error indicator.
- enc_cnt  output  CNT_W  accepted output beats, saturating.
- err_cnt  output  CNT_W  accepted output beats with out_err=1, saturating.
- clr  input  1  synchronous clear of err_flag, enc_cnt and err_cnt.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_inst=0, out_err=0, err_flag=0, enc_cnt=0, err_cnt=0. in_ready follows its equation, so it reads 1 during reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An input beat is taken when in_valid && in_ready.
  - A taken input beat appears on out_* the next cycle: latency 1, full throughput.
  - out_* holds stable while out_valid && !out_ready.
  - out_valid drops after an accept with no new input.
- Field insertion (all non-immediate bits copied from in_inst):
  - ITYPE: inst[31:20]=imm[11:0].
  - STYPE: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0].
  - BTYPE: inst[31]=imm[12]; inst[30:25]=imm[10:5]; inst[11:8]=imm[4:1]; inst[7]=imm[11].
  - UTYPE: inst[31:12]=imm[31:12].
  - JTYPE: inst[31]=imm[20]; inst[30:21]=imm[10:1]; inst[20]=imm[11]; inst[19:12]=imm[19:12].
  - RTYPE: in_inst unchanged; in_imm ignored.
  - Any other code: in_inst unchanged.
- Range check (err=1 when violated):
  - ITYPE/STYPE: imm[31:11] not all equal.
  - BTYPE: imm[31:12] not all equal, or imm[0]=1.
  - UTYPE: imm[11:0] != 0.
  - JTYPE: imm[31:20] not all equal, or imm[0]=1.
  - RTYPE: never an error.
  - Undefined type code: always an error.
- On error the instruction is still encoded with the truncated bits; out_err marks that beat.
- Counters:
  - On out_valid && out_ready: enc_cnt++; err_cnt++ if out_err; err_flag set if out_err.
  - Both counters saturate at 2^CNT_W-1, no wrap.
- clr:
  - Clears err_flag and both counters.
  - If an accept coincides with clr, the accepted beat counts after the clear: counter = 1 (err_flag=1 if that beat had err).
  - clr does not affect the data path.
- Reset mid-transfer: a pending output beat is discarded; no counter update for it.

Test Plan:
- ITYPE, in_inst=0x00000013, in_imm=0xFFFFFFFF, out_ready=1 -> next cycle out_inst=0xFFF00013, out_err=0, enc_cnt=1.
- BTYPE, in_inst=0x00000063, in_imm=0xFFFFFFFC -> out_inst=0xFE000EE3, out_err=0. Same beat with in_imm=0x00000003 -> out_err=1, err_cnt=1, err_flag=1.
- JTYPE, in_inst=0x0000006F, in_imm=0x00000800 -> out_inst=0x0010006F. UTYPE, in_inst=0x00000037: in_imm=0x12345000 -> 0x12345037, err=0; in_imm=0x12345001 -> 0x12345037, err=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_inst stable, enc_cnt unchanged. Release -> one beat per cycle, no loss or duplication across a 4-beat burst.
- Saturation and clear: preload enc_cnt to 0xFFFF via 65535 accepted beats, send one more -> stays 0xFFFF. Assert clr on the same cycle as an accepted error beat -> enc_cnt=1, err_cnt=1, err_flag=1.
- Drop rst_n asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 immediately, counters 0. After release the first new beat is encoded correctly.
